// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared ISA constants, fetch FSM encodings and PC helpers.
package fetch_unit_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response, redirect and decode-side signals of the fetch stage.
interface fetch_unit_if;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic        redirectValid;
  logic [31:0] redirectPC;
  logic        ifValid;
  logic [31:0] ifPC;
  logic [31:0] ifInstr;
  logic        ifReady;
  modport master (
    output imemReqValid, imemReqAddr, ifValid, ifPC, ifInstr,
    input  imemReqReady, imemRespValid, imemRespData, redirectValid, redirectPC, ifReady
  );
  modport slave (
    input  imemReqValid, imemReqAddr, ifValid, ifPC, ifInstr,
    output imemReqReady, imemRespValid, imemRespData, redirectValid, redirectPC, ifReady
  );
endinterface

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: one-entry instruction holding register between fetch and decode.
module fetch_out_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        accept,
  input  logic        flush,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else begin
      valid <= flush ? 1'b0 : load ? 1'b1 : accept ? 1'b0 : valid;
      if (load && !flush) begin
        pc    <= load_pc;
        instr <= load_instr;
      end
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM with redirect handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        accept;
  logic        resp_load;
  assign bus.imemReqValid = (state == ST_REQ) && (!bus.ifValid || bus.ifReady);
  assign bus.imemReqAddr  = pc;
  assign accept    = bus.imemReqValid && bus.imemReqReady;
  assign resp_load = (state == ST_WAIT) && bus.imemRespValid && !bus.redirectValid;
  // A redirect while a request is in flight turns its response into one to discard.
  always_comb begin
    state_nx = ST_REQ;
    state_nx = (state == ST_REQ)  ? (accept ? (bus.redirectValid ? ST_DROP : ST_WAIT) : ST_REQ) :
               (state == ST_WAIT) ? (bus.imemRespValid ? ST_REQ : bus.redirectValid ? ST_DROP : ST_WAIT) :
               (state == ST_DROP) ? (bus.imemRespValid ? ST_REQ : ST_DROP) :
               ST_REQ;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_REQ;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_nx;
      if (bus.redirectValid) pc <= word_align(bus.redirectPC);
      else if (resp_load) pc <= req_pc + 32'd4;
      if (accept) req_pc <= pc;
    end
  end
  fetch_out_reg u_out (
    .clk        (clk),
    .rst        (reset),
    .load       (resp_load),
    .accept     (bus.ifValid && bus.ifReady),
    .flush      (bus.redirectValid),
    .load_pc    (req_pc),
    .load_instr (bus.imemRespData),
    .valid      (bus.ifValid),
    .pc         (bus.ifPC),
    .instr      (bus.ifInstr)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue scoreboard for requests and deliveries.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  fetch_unit_if bus();
  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (.clk(clk), .reset(reset), .bus(bus));
  int vecs = 0;
  int errs = 0;
  int lat = 1;
  int cyc = 0;
  int c0 = 0;
  logic [31:0] exp_req[$];
  logic [31:0] exp_deliv[$];
  int dq[$];
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h2400_5A5A;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  // memory model: answers each accepted request lat cycles later
  initial begin
    int cnt;
    logic acc, rs;
    logic [31:0] aaddr, paddr;
    cnt = 0;
    paddr = '0;
    bus.imemRespValid = 1'b0;
    bus.imemRespData = '0;
    forever begin
      @(negedge clk);
      acc = bus.imemReqValid && bus.imemReqReady;
      aaddr = bus.imemReqAddr;
      rs = reset;
      @(posedge clk);
      #1;
      bus.imemRespValid = 1'b0;
      if (rs) cnt = 0;
      else if (acc === 1'b1) begin
        cnt = lat;
        paddr = aaddr;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.imemRespValid = 1'b1;
          bus.imemRespData = instr_of(paddr);
        end
      end
    end
  end
  // monitor
  initial begin
    logic [31:0] p;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.imemReqValid && bus.imemReqReady && exp_req.size() != 0)
          chk("req_addr", bus.imemReqAddr, exp_req.pop_front());
        if (bus.ifValid && bus.ifReady && exp_deliv.size() != 0) begin
          p = exp_deliv.pop_front();
          chk("if_pc", bus.ifPC, p);
          chk("if_instr", bus.ifInstr, instr_of(p));
          dq.push_back(cyc);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.redirectValid = 1'b0;
    bus.imemReqReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    c0 = cyc;
  endtask
  task automatic drain(input string n);
    int t;
    t = 0;
    while ((exp_req.size() + exp_deliv.size()) != 0 && t < 60) begin
      @(posedge clk);
      t++;
    end
    chk(n, exp_req.size() + exp_deliv.size(), 0);
    exp_req.delete();
    exp_deliv.delete();
    step();
    reset = 1'b1;
  endtask
  initial begin
    bus.imemReqReady = 1'b1;
    bus.redirectValid = 1'b0;
    bus.redirectPC = '0;
    bus.ifReady = 1'b1;
    // sequential fetch, 1-cycle memory
    lat = 1;
    exp_req.push_back(32'h3000); exp_req.push_back(32'h3004); exp_req.push_back(32'h3008);
    exp_deliv.push_back(32'h3000); exp_deliv.push_back(32'h3004); exp_deliv.push_back(32'h3008);
    dq.delete();
    do_reset();
    @(negedge clk);
    chk("rst_req_valid", bus.imemReqValid, 1);
    chk("rst_req_addr", bus.imemReqAddr, 32'h3000);
    chk("rst_if_valid", bus.ifValid, 0);
    chk("rst_if_pc", bus.ifPC, 0);
    chk("rst_if_instr", bus.ifInstr, 0);
    drain("seq_drain");
    chk("seq_count", dq.size(), 3);
    if (dq.size() >= 3) begin
      chk("seq_first_lat", dq[0] - c0, 2);
      chk("seq_gap1", dq[1] - dq[0], 2);
      chk("seq_gap2", dq[2] - dq[1], 2);
    end
    // decode stall
    bus.ifReady = 1'b0;
    exp_req.push_back(32'h3000); exp_req.push_back(32'h3004);
    exp_deliv.push_back(32'h3000); exp_deliv.push_back(32'h3004);
    do_reset();
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", bus.ifValid, 1);
      chk("stall_pc", bus.ifPC, 32'h3000);
      chk("stall_instr", bus.ifInstr, instr_of(32'h3000));
      chk("stall_req_valid", bus.imemReqValid, 0);
    end
    step();
    bus.ifReady = 1'b1;
    drain("stall_drain");
    // redirect while waiting on 3-cycle memory
    lat = 3;
    exp_req.push_back(32'h3000); exp_req.push_back(32'h4010);
    exp_deliv.push_back(32'h4010);
    do_reset();
    step();
    bus.redirectValid = 1'b1;
    bus.redirectPC = 32'h4010;
    step();
    bus.redirectValid = 1'b0;
    drain("wait_redir_drain");
    // redirect coinciding with the response
    lat = 1;
    exp_req.push_back(32'h3000); exp_req.push_back(32'h6000);
    exp_deliv.push_back(32'h6000);
    do_reset();
    step();
    bus.redirectValid = 1'b1;
    bus.redirectPC = 32'h6000;
    step();
    bus.redirectValid = 1'b0;
    @(negedge clk);
    chk("coinc_req_valid", bus.imemReqValid, 1);
    chk("coinc_req_addr", bus.imemReqAddr, 32'h6000);
    chk("coinc_if_valid", bus.ifValid, 0);
    drain("coinc_drain");
    // back-to-back redirects while not accepted, misaligned target
    exp_req.push_back(32'h5000);
    exp_deliv.push_back(32'h5000);
    do_reset();
    bus.imemReqReady = 1'b0;
    bus.redirectValid = 1'b1;
    bus.redirectPC = 32'h7000;
    step();
    bus.redirectPC = 32'h5003;
    step();
    bus.redirectValid = 1'b0;
    bus.imemReqReady = 1'b1;
    @(negedge clk);
    chk("align_req_addr", bus.imemReqAddr, 32'h5000);
    drain("align_drain");
    // wrap at top of address space
    exp_req.push_back(32'hFFFF_FFFC); exp_req.push_back(32'h0000_0000);
    exp_deliv.push_back(32'hFFFF_FFFC); exp_deliv.push_back(32'h0000_0000);
    do_reset();
    bus.imemReqReady = 1'b0;
    bus.redirectValid = 1'b1;
    bus.redirectPC = 32'hFFFF_FFFC;
    step();
    bus.redirectValid = 1'b0;
    bus.imemReqReady = 1'b1;
    drain("wrap_drain");
    // reset while dropping
    lat = 3;
    exp_req.push_back(32'h3000);
    do_reset();
    step();
    bus.redirectValid = 1'b1;
    bus.redirectPC = 32'h4010;
    step();
    bus.redirectValid = 1'b0;
    reset = 1'b1;
    exp_req.delete();
    exp_req.push_back(32'h3000);
    exp_deliv.push_back(32'h3000);
    do_reset();
    @(negedge clk);
    chk("drop_rst_req_valid", bus.imemReqValid, 1);
    chk("drop_rst_req_addr", bus.imemReqAddr, 32'h3000);
    chk("drop_rst_if_valid", bus.ifValid, 0);
    drain("drop_rst_drain");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the MIPS pipeline. It owns the architectural fetch PC and issues single-outstanding requests to instruction memory. It latches each returned word into a one-entry output register that feeds decode, and accepts the next-PC redirect computed by the downstream next-PC logic for branches, jumps and `jr`. Between redirects it fetches sequentially at PC+4.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `imemReqValid`  out  1  request presented this cycle.
- `imemReqAddr`  out  32  word address of request (always [1:0]=0).
- `imemReqReady`  in  1  memory accepts request this cycle.
- `imemRespValid`  in  1  response word valid.
- `imemRespData`  in  32  instruction word.
- `redirectValid`  in  1  control-flow redirect this cycle.
- `redirectPC`  in  32  target PC; bits [1:0] ignored (forced 0).
- `ifValid`  out  1  output register holds an instruction.
- `ifPC`  out  32  PC of the held instruction.
- `ifInstr`  out  32  held instruction.
- `ifReady`  in  1  decode accepts the held instruction this cycle.

## Operation
- Registers: `pc`, `reqPC`, state, `ifValid`/`ifPC`/`ifInstr`.
- States:
  - REQ: requesting.
  - WAIT: one request outstanding, response kept.
  - DROP: one request outstanding, response discarded.
- `imemReqValid = (state==REQ) && (!ifValid || ifReady)`, registered-state based, no dependence on `redirectValid`. `imemReqAddr = pc`.
- REQ, request accepted (`imemReqValid && imemReqReady`):
  - `reqPC <= pc`.
  - Next state is WAIT, or DROP if `redirectValid`.
- REQ, not accepted: stay in REQ.
- WAIT, `imemRespValid` without redirect:
  - `ifValid <= 1`, `ifPC <= reqPC`, `ifInstr <= imemRespData`.
  - `pc <= reqPC + 4` (mod 2^32, wraps 32'hFFFF_FFFC to 0).
  - Next state is REQ.
- WAIT, redirect without response: next state is DROP.
- WAIT, redirect and response in the same cycle: response discarded, next state is REQ.
- DROP, `imemRespValid`: response discarded, next state is REQ. A redirect in the same cycle updates `pc` only.
- Any state, `redirectValid`:
  - `pc <= {redirectPC[31:2],2'b00}`.
  - `ifValid <= 0`; redirect overrides a same-cycle response load.
  - A decode transfer (`ifValid && ifReady`) in that same cycle still counts as delivered.
- Output register: `ifValid` clears on `ifValid && ifReady` unless reloaded in the same cycle. It holds `ifPC`/`ifInstr` stable while `ifValid && !ifReady`.
- Response arriving in REQ is a protocol error; it is ignored and does not change state.
- Redirects in consecutive cycles: the last one wins.

## Timing
- Reset, applied on the edge: `pc=RESET_PC`, state REQ, `ifValid=0`, `ifPC=0`, `ifInstr=0`, `reqPC=0`.
  - In the first cycle after reset, `imemReqValid=1` and `imemReqAddr=RESET_PC`.
  - Reset mid-transfer abandons any outstanding request. Memory shares `reset`, so no stale response follows.
- Memory response latency is ≥1 cycle after acceptance, in order. At most one request is outstanding.
- Throughput: with 1-cycle memory and `ifReady` held high, one instruction every 2 cycles. `ifValid` rises the cycle after `imemRespValid`.
- Redirect to first request at the new target:
  - Next cycle if in REQ or WAIT-with-response.
  - Otherwise, the cycle after the dropped response.
- `imemReqAddr` may change while unaccepted, only due to redirect. Memory samples the address only on acceptance.

## Structure
- State encodings (REQ/WAIT/DROP, 2 bits) and the `RESET_PC` default go in the shared ISA/constants header, next to the opcode definitions.
- One natural sub-module: `fetch_out_reg`, the one-entry `ifValid`/`ifPC`/`ifInstr` holding register with load/accept/flush inputs.
- The FSM and PC logic stay in `fetch_unit`.

## Test plan
- Reset with `RESET_PC=32'h0000_3000`, 1-cycle memory, `ifReady=1` → `ifPC` sequence 3000, 3004, 3008 at 2-cycle spacing, `ifInstr` matching memory.
- Decode stalls (`ifReady=0`) for 5 cycles with `ifValid=1`:
  - `ifPC`/`ifInstr` stay constant.
  - `imemReqValid=0` throughout.
  - After release, the next fetch is at `ifPC+4`.
- Redirect to 32'h0000_4010 while in WAIT (3-cycle memory):
  - Response for the old PC is dropped and `ifValid` never shows it.
  - Next `imemReqAddr=4010`; the next delivered `ifPC=4010`.
- Redirect coinciding with `imemRespValid` in WAIT → word not delivered, next request at target the following cycle.
- Redirect with `redirectPC=32'h0000_5003` → `imemReqAddr=5000`. Sequential fetch from `pc=32'hFFFF_FFFC` → next request at 0.
- Assert `reset` while in DROP → the cycle after reset release, request at `RESET_PC`, `ifValid=0`.
